// File: rtl/lif_spike_evt_encoder_pkg.sv
// Shared types, op codes and helpers for the spike-vector event encoder.
// Revision: 1.0
`default_nettype none

package lif_spike_evt_encoder_pkg;

  localparam logic [2:0] NOP_OP   = 3'd0;
  localparam logic [2:0] SPIKE_OP = 3'd1;

  localparam int SPK_N      = 16;
  localparam int SPK_GID_W  = 8;
  localparam int SPK_TIME_W = 8;

  typedef struct packed {
    logic [SPK_N-1:0]      vec;
    logic [SPK_GID_W-1:0]  gid;
    logic [SPK_TIME_W-1:0] tstamp;
  } spk_vec_entry_t;

  typedef enum logic [0:0] {
    ENC_IDLE = 1'b0,
    ENC_SCAN = 1'b1
  } enc_state_t;

  localparam int LSB_MAX_W = 256;

  // Index of the lowest set bit; returns 0 for an all-zero vector.
  function automatic logic [7:0] lowest_set_idx(input logic [LSB_MAX_W-1:0] v);
    logic [7:0] idx;
    idx = '0;
    for (int i = LSB_MAX_W - 1; i >= 0; i--) begin
      if (v[i]) idx = 8'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lif_spike_evt_encoder_fifo.sv
// Parametric synchronous FIFO with flush and simultaneous push/pop.
// Revision: 1.0
`default_nettype none

module spk_enc_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count == (AW+1)'(DEPTH));
  assign empty_o = (count == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem[wr_ptr] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/lif_spike_evt_encoder.sv
// Buffers non-empty spike vectors and serialises them into one SPIKE_OP event per set bit.
// Revision: 1.0
`default_nettype none

module lif_spike_evt_encoder
  import lif_spike_evt_encoder_pkg::*;
#(
  parameter int N_NEURONS      = SPK_N,
  parameter int GROUP_ID_WIDTH = SPK_GID_W,
  parameter int TIME_WIDTH     = SPK_TIME_W,
  parameter int FIFO_DEPTH     = 4,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          enable_i,
  input  logic                                          clear_i,
  input  logic                                          spike_valid_i,
  input  logic [N_NEURONS-1:0]                          spike_vec_i,
  input  logic [GROUP_ID_WIDTH-1:0]                     group_id_i,
  input  logic [TIME_WIDTH-1:0]                         time_i,
  output logic                                          spike_ready_o,
  output logic                                          evt_valid_o,
  input  logic                                          evt_ready_i,
  output logic [2:0]                                    evt_op_o,
  output logic [GROUP_ID_WIDTH+$clog2(N_NEURONS)-1:0]   evt_nid_o,
  output logic [TIME_WIDTH-1:0]                         evt_time_o,
  output logic                                          busy_o,
  output logic [DROP_CNT_WIDTH-1:0]                     drop_cnt_o
);

  localparam int IDX_W   = $clog2(N_NEURONS);
  localparam int ENTRY_W = N_NEURONS + GROUP_ID_WIDTH + TIME_WIDTH;

  enc_state_t                state;
  enc_state_t                state_nxt;
  logic [N_NEURONS-1:0]      mask;
  logic [GROUP_ID_WIDTH-1:0] hold_gid;
  logic [TIME_WIDTH-1:0]     hold_time;

  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_pop;
  logic [ENTRY_W-1:0]        fifo_head;
  logic [N_NEURONS-1:0]      head_vec;
  logic [GROUP_ID_WIDTH-1:0] head_gid;
  logic [TIME_WIDTH-1:0]     head_time;

  logic                      vec_hit;
  logic                      wr_en;
  logic                      load;
  logic                      handshake;
  logic                      last_bit;
  logic [IDX_W-1:0]          cur_idx;
  logic [N_NEURONS-1:0]      cur_bit;

  // Clear discards the incoming vector without counting it as a drop.
  assign vec_hit = spike_valid_i & enable_i & (|spike_vec_i) & ~clear_i;
  assign wr_en   = vec_hit & ~fifo_full;

  spk_enc_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (clear_i),
    .push_i  (wr_en),
    .data_i  ({spike_vec_i, group_id_i, time_i}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {head_vec, head_gid, head_time} = fifo_head;

  assign cur_idx   = IDX_W'(lowest_set_idx(LSB_MAX_W'(mask)));
  assign cur_bit   = N_NEURONS'(1) << cur_idx;
  assign last_bit  = ((mask & ~cur_bit) == '0);
  assign handshake = (state == ENC_SCAN) & evt_ready_i;

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    load      = 1'b0;
    case (state)
      ENC_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          load      = 1'b1;
          state_nxt = ENC_SCAN;
        end
      end
      ENC_SCAN: begin
        // Refill on the final handshake so consecutive vectors stream without a bubble.
        if (evt_ready_i && last_bit) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            load     = 1'b1;
          end else begin
            state_nxt = ENC_IDLE;
          end
        end
      end
      default: state_nxt = ENC_IDLE;
    endcase
    if (clear_i) begin
      state_nxt = ENC_IDLE;
      fifo_pop  = 1'b0;
      load      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ENC_IDLE;
      mask      <= '0;
      hold_gid  <= '0;
      hold_time <= '0;
    end else begin
      state <= state_nxt;
      if (clear_i) begin
        mask <= '0;
      end else if (load) begin
        mask      <= head_vec;
        hold_gid  <= head_gid;
        hold_time <= head_time;
      end else if (handshake) begin
        mask <= mask & ~cur_bit;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_cnt_o <= '0;
    end else if (vec_hit && fifo_full && !(&drop_cnt_o)) begin
      drop_cnt_o <= drop_cnt_o + DROP_CNT_WIDTH'(1);
    end
  end

  assign spike_ready_o = ~fifo_full;
  assign evt_valid_o   = (state == ENC_SCAN);
  assign evt_op_o      = evt_valid_o ? SPIKE_OP : NOP_OP;
  assign evt_nid_o     = {hold_gid, cur_idx};
  assign evt_time_o    = hold_time;
  assign busy_o        = ~fifo_empty | (state == ENC_SCAN);

endmodule

`default_nettype wire

// File: tb/tb_lif_spike_evt_encoder.sv
// Scoreboard bench for lif_spike_evt_encoder against a queue-level reference model.
`default_nettype none

module tb_lif_spike_evt_encoder;
  import lif_spike_evt_encoder_pkg::*;

  localparam int N     = 16;
  localparam int GW    = 8;
  localparam int TW    = 8;
  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int NW    = GW + 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          clear;
  logic          spike_valid;
  logic [N-1:0]  vec;
  logic [GW-1:0] gid;
  logic [TW-1:0] tm;
  logic          evt_ready;
  logic          spike_ready;
  logic          evt_valid;
  logic [2:0]    evt_op;
  logic [NW-1:0] evt_nid;
  logic [TW-1:0] evt_time;
  logic          busy;
  logic [DW-1:0] drop_cnt;

  int total = 0;
  int bad   = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  lif_spike_evt_encoder #(
    .N_NEURONS(N), .GROUP_ID_WIDTH(GW), .TIME_WIDTH(TW),
    .FIFO_DEPTH(DEPTH), .DROP_CNT_WIDTH(DW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
    .spike_valid_i(spike_valid), .spike_vec_i(vec), .group_id_i(gid), .time_i(tm),
    .spike_ready_o(spike_ready), .evt_valid_o(evt_valid), .evt_ready_i(evt_ready),
    .evt_op_o(evt_op), .evt_nid_o(evt_nid), .evt_time_o(evt_time),
    .busy_o(busy), .drop_cnt_o(drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: whole entries in a queue, remaining events of the held vector as a count.
  typedef struct {
    logic [NW-1:0] nid;
    logic [TW-1:0] t;
  } exp_evt_t;

  exp_evt_t       exp_q[$];
  spk_vec_entry_t m_fifo[$];
  int             m_hold;
  logic [DW-1:0]  m_drop;

  always @(posedge clk or posedge rst) begin
    bit pre_full;
    bit pre_empty;
    spk_vec_entry_t ent;
    exp_evt_t e;
    if (rst) begin
      m_fifo.delete();
      exp_q.delete();
      m_hold = 0;
      m_drop = '0;
    end else if (clear) begin
      m_fifo.delete();
      exp_q.delete();
      m_hold = 0;
    end else begin
      pre_full  = (m_fifo.size() == DEPTH);
      pre_empty = (m_fifo.size() == 0);
      if (m_hold == 0) begin
        if (!pre_empty) begin
          m_hold = $countones(m_fifo[0].vec);
          void'(m_fifo.pop_front());
        end
      end else if (evt_ready) begin
        m_hold--;
        if (m_hold == 0 && !pre_empty) begin
          m_hold = $countones(m_fifo[0].vec);
          void'(m_fifo.pop_front());
        end
      end
      if (spike_valid && enable && vec != '0) begin
        if (!pre_full) begin
          ent.vec = vec; ent.gid = gid; ent.tstamp = tm;
          m_fifo.push_back(ent);
          for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
              e.nid = NW'(gid) * NW'(N) + NW'(i);
              e.t   = tm;
              exp_q.push_back(e);
            end
          end
        end else if (m_drop != {DW{1'b1}}) begin
          m_drop = m_drop + 1'b1;
        end
      end
    end
  end

  // Monitor: per-cycle status checks plus scoreboard pops on every handshake.
  logic          prev_stall;
  logic [NW-1:0] prev_nid;
  logic [TW-1:0] prev_time;

  always @(negedge clk) begin
    exp_evt_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      chk("valid", 32'(evt_valid), 32'(m_hold != 0));
      chk("busy", 32'(busy), 32'((m_fifo.size() != 0) || (m_hold != 0)));
      chk("spike_ready", 32'(spike_ready), 32'(m_fifo.size() < DEPTH));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (evt_valid) begin
        chk("op", 32'(evt_op), 32'(SPIKE_OP));
        if (prev_stall) begin
          chk("stable_nid", 32'(evt_nid), 32'(prev_nid));
          chk("stable_time", 32'(evt_time), 32'(prev_time));
        end
        if (evt_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_evt", 32'(evt_nid), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("evt_nid", 32'(evt_nid), 32'(e.nid));
            chk("evt_time", 32'(evt_time), 32'(e.t));
          end
        end
      end
      prev_stall = evt_valid && !evt_ready;
      prev_nid   = evt_nid;
      prev_time  = evt_time;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] v, input logic [GW-1:0] g, input logic [TW-1:0] t);
    spike_valid = 1'b1; vec = v; gid = g; tm = t;
    step();
    spike_valid = 1'b0; vec = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    evt_ready = 1'b1;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n >= 300), 32'd0);
  endtask

  initial begin
    int hs0;
    rst = 1'b1; enable = 1'b1; clear = 1'b0; spike_valid = 1'b0;
    vec = '0; gid = '0; tm = '0; evt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_ready", 32'(spike_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_op", 32'(evt_op), 32'd0);
    rst = 1'b0;
    step();

    // Single vector: latency and ascending bit order.
    send(16'h0091, 8'd3, 8'h2A);
    chk("lat_not_yet", 32'(evt_valid), 32'd0);
    step();
    chk("s1_nid0", 32'(evt_nid), 32'h030);
    chk("s1_v0", 32'(evt_valid), 32'd1);
    chk("s1_time", 32'(evt_time), 32'h2A);
    step();
    chk("s1_nid1", 32'(evt_nid), 32'h034);
    step();
    chk("s1_nid2", 32'(evt_nid), 32'h037);
    step();
    chk("s1_idle_valid", 32'(evt_valid), 32'd0);
    chk("s1_idle_busy", 32'(busy), 32'd0);

    // Back-to-back vectors stream without a bubble.
    send(16'h8000, 8'd1, 8'h10);
    send(16'h0001, 8'd2, 8'h11);
    chk("b2b_nid0", 32'(evt_nid), 32'h01F);
    step();
    chk("b2b_nid1", 32'(evt_nid), 32'h020);
    chk("b2b_valid1", 32'(evt_valid), 32'd1);
    drain();

    // Backpressure: ready toggles every cycle.
    hs0 = hs_cnt;
    send(16'h0091, 8'd3, 8'h2A);
    for (int i = 0; i < 12; i++) begin
      evt_ready = i[0];
      step();
    end
    drain();
    chk("bp_handshakes", 32'(hs_cnt - hs0), 32'd3);

    // Overflow: five buffered (one held), sixth dropped.
    evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(16'h0003, 8'(8'h40 + i), 8'(i));
    chk("ovf_drop", 32'(drop_cnt), 32'd1);
    chk("ovf_ready", 32'(spike_ready), 32'd0);
    drain();
    chk("ovf_drop_after", 32'(drop_cnt), 32'd1);

    // Filtering: zero vector and disabled input write nothing.
    send(16'h0000, 8'd5, 8'h01);
    enable = 1'b0;
    send(16'h00F0, 8'd5, 8'h02);
    enable = 1'b1;
    step();
    chk("filt_busy", 32'(busy), 32'd0);
    chk("filt_valid", 32'(evt_valid), 32'd0);
    chk("filt_drop", 32'(drop_cnt), 32'd1);

    // Clear mid-scan with two entries buffered.
    evt_ready = 1'b0;
    send(16'h0101, 8'd7, 8'h20);
    send(16'h0202, 8'd8, 8'h21);
    send(16'h0404, 8'd9, 8'h22);
    clear = 1'b1;
    spike_valid = 1'b1; vec = 16'h0001;
    step();
    clear = 1'b0; spike_valid = 1'b0; vec = '0;
    chk("clr_valid", 32'(evt_valid), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_drop", 32'(drop_cnt), 32'd1);
    step();
    chk("clr_stays_idle", 32'(busy), 32'd0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      spike_valid = ($urandom_range(0, 3) != 0);
      enable      = ($urandom_range(0, 7) != 0);
      vec         = ($urandom_range(0, 5) == 0) ? '0 : (N'($urandom) & N'($urandom));
      gid         = GW'($urandom);
      tm          = TW'($urandom);
      evt_ready   = ($urandom_range(0, 3) != 0);
      clear       = ($urandom_range(0, 49) == 0);
      step();
    end
    spike_valid = 1'b0; enable = 1'b1; clear = 1'b0; vec = '0;
    drain();

    // Asynchronous reset mid-scan.
    evt_ready = 1'b0;
    send(16'h0F00, 8'd6, 8'h33);
    step();
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(evt_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(spike_ready), 32'd1);
    chk("arst_drop", 32'(drop_cnt), 32'd0);
    chk("arst_nid", 32'(evt_nid), 32'd0);
    chk("arst_time", 32'(evt_time), 32'd0);
    step();
    rst = 1'b0;
    evt_ready = 1'b1;
    repeat (4) step();
    chk("arst_no_evt", 32'(evt_valid), 32'd0);

    // Drop counter saturation, then clear must keep it.
    evt_ready = 1'b0;
    spike_valid = 1'b1; vec = 16'h0010; gid = 8'hA5; tm = 8'h5A;
    repeat (65540 + DEPTH + 2) step();
    spike_valid = 1'b0; vec = '0;
    chk("sat_drop", 32'(drop_cnt), 32'hFFFF);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("sat_after_clear", 32'(drop_cnt), 32'hFFFF);
    chk("sat_clear_busy", 32'(busy), 32'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
